jb_pulse_shaper: RTL and testbench
==================================

// Module: jb_pulse_shaper
// PURPOSE
//  Output-side counterpart of the input debouncer. Drives a slow external
//  output (LED, relay, opto, pin to another board) from single-cycle internal
//  event pulses. Every active phase has a guaranteed minimum width and every
//  idle gap has a guaranteed minimum width, so the far-end receiver/debouncer
//  sees each event as a clean, stable level. Events arriving while the output
//  is busy are queued in a saturating counter, not lost.
// PARAMETERS
//  HIGH_CYCLES  16  clk periods dout is held active per event (>=1, <2**COUNTER_BITS)
//  LOW_CYCLES   16  clk periods dout is held idle after each active phase (>=1, <2**COUNTER_BITS)
//  COUNTER_BITS 8   width of the phase timer
//  PEND_BITS    4   width of pending-event counter; max queued = 2**PEND_BITS-1
//  IDLE_LEVEL   0   dout level when idle; active level = ~IDLE_LEVEL
// PORTS
//  clk       in   1          system clock, all logic on rising edge
//  rst_n     in   1          asynchronous, active-low reset
//  pulse_in  in   1          event request; each cycle sampled high = one event
//  clr_ovf   in   1          synchronous clear of overflow flag
//  dout      out  1          shaped output to external pin
//  busy      out  1          1 when state != IDLE
//  pend_cnt  out  PEND_BITS  events queued, not yet started
//  overflow  out  1          sticky: an event was dropped (queue full)
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): dout=IDLE_LEVEL, state=IDLE,
//   timer=0, pend_cnt=0, overflow=0, busy=0. Reset mid-phase aborts the phase
//   immediately and discards the queue.
//  FSM states: IDLE, ACTIVE, GAP.
//   IDLE:   if pulse_in | (pend_cnt!=0) -> ACTIVE, consume one event, timer=0.
//   ACTIVE: dout=~IDLE_LEVEL; timer counts; at timer==HIGH_CYCLES-1 -> GAP, timer=0.
//   GAP:    dout=IDLE_LEVEL; at timer==LOW_CYCLES-1 -> ACTIVE (consume one) if
//           pend_cnt!=0 or pulse_in, else -> IDLE.
//  dout is a registered output, driven directly from state (glitch-free).
//  Latency: pulse_in sampled at edge N in IDLE -> dout active after edge N,
//   held exactly HIGH_CYCLES periods, then idle >= LOW_CYCLES periods.
//  Queue: pulse_in not consumed in the same cycle -> pend_cnt+1. Consume with no
//   pulse_in -> pend_cnt-1. Consume and pulse_in in same cycle -> pend_cnt
//   unchanged (new event takes the slot). pulse_in in IDLE is consumed directly,
//   pend_cnt stays 0.
//  Full: pulse_in while pend_cnt==2**PEND_BITS-1 and no consume -> event dropped,
//   pend_cnt holds, overflow<=1. Never wraps.
//  overflow: sticky until clr_ovf; set and clr_ovf in same cycle -> stays 1.
//  busy = (state!=IDLE); also 1 during GAP, so events back-to-back are spaced by
//   exactly HIGH_CYCLES+LOW_CYCLES periods.
//  pulse_in held high for K cycles = K events (level is not edge-detected).
// TESTING (HIGH_CYCLES=4, LOW_CYCLES=3, PEND_BITS=2, IDLE_LEVEL=0)
//  1 Reset: rst_n=0 mid-ACTIVE -> dout=0, busy=0, pend_cnt=0 same cycle; stays 0.
//  2 Single pulse_in at edge 10 -> dout=1 for edges 11..14 (4 periods), 0 from
//    edge 15, busy=0 after edge 17, pend_cnt=0 throughout.
//  3 pulse_in high 3 cycles from IDLE -> three active phases of 4, gaps of 3,
//    rising edges 7 cycles apart; pend_cnt peaks 2 then decrements 2,1,0.
//  4 pulse_in high 5 cycles -> pend_cnt saturates 3, overflow=1, exactly 4
//    active phases emitted; clr_ovf=1 -> overflow=0 next cycle.
//  5 pulse_in on last GAP cycle with pend_cnt=0 -> next ACTIVE starts with no
//    idle slip, pend_cnt stays 0; clr_ovf with drop same cycle -> overflow=1.

Source files
------------

// File: rtl/jb_pulse_shaper.sv
// jb_pulse_shaper: stretches single-cycle events into min-width active phases separated by min-width idle gaps
module jb_pulse_shaper #(
  parameter int HIGH_CYCLES = 16,
  parameter int LOW_CYCLES = 16,
  parameter int COUNTER_BITS = 8,
  parameter int PEND_BITS = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse_in,
  input  logic                 clr_ovf,
  output logic                 dout,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pend_cnt,
  output logic                 overflow
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  localparam logic [COUNTER_BITS-1:0] H_LAST = COUNTER_BITS'(HIGH_CYCLES - 1);
  localparam logic [COUNTER_BITS-1:0] L_LAST = COUNTER_BITS'(LOW_CYCLES - 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
  state_t state;
  logic [COUNTER_BITS-1:0] timer;
  logic have, hi_done, lo_done, consume, drop;
  assign have = pulse_in | (pend_cnt != '0);
  assign hi_done = (state == ACTIVE) && (timer == H_LAST);
  assign lo_done = (state == GAP) && (timer == L_LAST);
  assign consume = have & ((state == IDLE) | lo_done);
  assign drop = pulse_in & ~consume & (pend_cnt == PEND_MAX);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
      dout <= IDLE_LEVEL;
      busy <= 1'b0;
    end else begin
      overflow <= (overflow & ~clr_ovf) | drop;
      // a new event arriving while one is consumed simply takes its slot
      if (pulse_in & ~consume & ~drop)
        pend_cnt <= pend_cnt + 1'b1;
      else if (consume & ~pulse_in)
        pend_cnt <= pend_cnt - 1'b1;
      if (consume) begin
        state <= ACTIVE;
        timer <= '0;
        dout <= ~IDLE_LEVEL;
        busy <= 1'b1;
      end else if (hi_done) begin
        state <= GAP;
        timer <= '0;
        dout <= IDLE_LEVEL;
      end else if (lo_done) begin
        state <= IDLE;
        timer <= '0;
        busy <= 1'b0;
      end else if (state != IDLE) begin
        timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jb_pulse_shaper.sv
// tb_jb_pulse_shaper: scoreboard bench comparing the shaper against a phase-countdown reference
module tb_jb_pulse_shaper;
  localparam int H = 4;
  localparam int L = 3;
  localparam int PMAX = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_in = 1'b0;
  logic clr_ovf = 1'b0;
  logic dout, busy, overflow;
  logic [1:0] pend_cnt;
  int n_vec = 0;
  int n_err = 0;
  logic [4:0] sb[$];
  int ms, mrem, mp;
  bit mo;
  int cyc = 0;
  int pk = 0;
  logic prev = 1'b0;
  int rises[$];

  jb_pulse_shaper #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES(L),
    .COUNTER_BITS(8),
    .PEND_BITS(2),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pulse_in(pulse_in),
    .clr_ovf(clr_ovf),
    .dout(dout),
    .busy(busy),
    .pend_cnt(pend_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference: ms 0=idle 1=active 2=gap, mrem = periods left in current phase
  task automatic model(input bit p, input bit c);
    bit cons, drop;
    cons = 1'b0;
    drop = 1'b0;
    if (!rst_n) begin
      ms = 0; mrem = 0; mp = 0; mo = 1'b0;
      return;
    end
    if (ms == 1) begin
      mrem--;
      if (mrem == 0) begin
        ms = 2;
        mrem = L;
      end
    end else if (ms == 2 && mrem > 1) begin
      mrem--;
    end else if (p || mp > 0) begin
      ms = 1;
      mrem = H;
      cons = 1'b1;
    end else begin
      ms = 0;
    end
    if (p && !cons) begin
      if (mp == PMAX) drop = 1'b1;
      else mp++;
    end else if (!p && cons) begin
      mp--;
    end
    mo = (mo && !c) || drop;
  endtask

  task automatic cycle(input bit p, input bit c);
    logic [4:0] e;
    pulse_in = p;
    clr_ovf = c;
    model(p, c);
    sb.push_back({ms == 1, ms != 0, 2'(mp), mo});
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("dout", 8'(dout), 8'(e[4]));
    chk("busy", 8'(busy), 8'(e[3]));
    chk("pend_cnt", 8'(pend_cnt), 8'(e[2:1]));
    chk("overflow", 8'(overflow), 8'(e[0]));
    if (dout && !prev) rises.push_back(cyc);
    prev = dout;
    if (int'(pend_cnt) > pk) pk = int'(pend_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ms = 0; mrem = 0; mp = 0; mo = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    // single event: 4 active periods, 3 gap periods, then idle
    rises.delete();
    cycle(1'b1, 1'b0);
    chk("t2_dout_rise", 8'(dout), 8'd1);
    idle(3);
    chk("t2_dout_held", 8'(dout), 8'd1);
    idle(1);
    chk("t2_dout_fall", 8'(dout), 8'd0);
    idle(2);
    chk("t2_busy_gap", 8'(busy), 8'd1);
    idle(1);
    chk("t2_busy_done", 8'(busy), 8'd0);
    chk("t2_rises", 8'(rises.size()), 8'd1);
    // three held cycles -> three phases spaced H+L apart
    rises.delete();
    pk = 0;
    repeat (3) cycle(1'b1, 1'b0);
    idle(25);
    chk("t3_rises", 8'(rises.size()), 8'd3);
    if (rises.size() == 3) begin
      chk("t3_space1", 8'(rises[1] - rises[0]), 8'(H + L));
      chk("t3_space2", 8'(rises[2] - rises[1]), 8'(H + L));
    end
    chk("t3_peak", 8'(pk), 8'd2);
    // saturation and overflow
    rises.delete();
    repeat (5) cycle(1'b1, 1'b0);
    chk("t4_pend_sat", 8'(pend_cnt), 8'd3);
    chk("t4_ovf_set", 8'(overflow), 8'd1);
    idle(30);
    chk("t4_rises", 8'(rises.size()), 8'd4);
    chk("t4_ovf_sticky", 8'(overflow), 8'd1);
    cycle(1'b0, 1'b1);
    chk("t4_ovf_clr", 8'(overflow), 8'd0);
    // event on last gap cycle starts next phase with no slip
    cycle(1'b1, 1'b0);
    idle(6);
    chk("t5_in_gap", 8'(dout), 8'd0);
    cycle(1'b1, 1'b0);
    chk("t5_no_slip", 8'(dout), 8'd1);
    chk("t5_pend0", 8'(pend_cnt), 8'd0);
    idle(8);
    // drop and clear in the same cycle keeps overflow set
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("t5_ovf_win", 8'(overflow), 8'd1);
    idle(40);
    cycle(1'b0, 1'b1);
    // async reset mid-active with a non-empty queue
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t1_pre_dout", 8'(dout), 8'd1);
    chk("t1_pre_pend", 8'(pend_cnt), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_dout", 8'(dout), 8'd0);
    chk("t1_rst_busy", 8'(busy), 8'd0);
    chk("t1_rst_pend", 8'(pend_cnt), 8'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    chk("t1_after_busy", 8'(busy), 8'd0);
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
